cp0_exception_unit: RTL and testbench

- Terminates the ExceptinPipeType bundle at the MEM stage.
- Prioritises the exception flags, updates CP0 state (BadVAddr, Count, Compare, Status, Cause, EPC) and issues the pipeline flush plus redirect PC.
- Also services MFC0 reads (MEM side) and MTC0 writes (WB side, gated by RegsWrType.CP0Wr).

---
 rtl/cp0_exception_unit_pkg.sv | 62 ++++++
 rtl/cp0_exception_unit_if.sv | 39 +++
 rtl/cp0_timer.sv | 46 ++++
 rtl/cp0_exception_unit.sv | 176 +++++++++++++++++
 tb/tb_cp0_exception_unit.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cp0_exception_unit_pkg.sv
// cp0_exception_unit shared definitions: CP0 register numbers,
// ExcCode values, Status/Cause layouts and MTC0 write masks.
package cp0_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Bit positions inside the ExceptinPipeType bundle
    localparam int EF_INT    = 0;
    localparam int EF_IFADDR = 1;
    localparam int EF_RI     = 2;
    localparam int EF_OV     = 3;
    localparam int EF_SYS    = 4;
    localparam int EF_BRK    = 5;
    localparam int EF_RDADDR = 6;
    localparam int EF_WRADDR = 7;
    localparam int EF_ERET   = 8;

    typedef logic [8:0] exc_flags_t;

    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    typedef struct packed {
        logic [8:0] rsvd_hi;
        logic       bev;
        logic [5:0] rsvd_mid;
        logic [7:0] im;
        logic [5:0] rsvd_lo;
        logic       exl;
        logic       ie;
    } status_t;

    typedef struct packed {
        logic        bd;
        logic        ti;
        logic [13:0] rsvd_hi;
        logic [7:0]  ip;
        logic        rsvd_mid;
        logic [4:0]  exc_code;
        logic [1:0]  rsvd_lo;
    } cause_t;

    typedef enum logic [1:0] {
        BVA_KEEP,
        BVA_PC,
        BVA_ALU
    } bva_sel_e;

endpackage

// File: rtl/cp0_exception_unit_if.sv
// MEM-stage exception bundle, MFC0/MTC0 ports and flush/redirect
// outputs of the CP0 exception unit.
interface cp0_exception_unit_if;
    import cp0_pkg::*;

    logic        MEM_Valid;
    exc_flags_t  MEM_ExceptType;
    logic [31:0] MEM_PC;
    logic [31:0] MEM_ALUOut;
    logic        MEM_InDelaySlot;
    logic [5:0]  Ext_Int;
    logic [4:0]  CP0_RdAddr;
    logic [31:0] CP0_RdData;
    logic        WB_CP0Wr;
    logic [4:0]  WB_CP0Addr;
    logic [31:0] WB_CP0Data;
    logic        Exc_Flush;
    logic [31:0] Exc_NPC;
    logic [31:0] CP0_Status;
    logic [31:0] CP0_Cause;
    logic [31:0] CP0_EPC;

    modport master (
        output MEM_Valid, MEM_ExceptType, MEM_PC, MEM_ALUOut,
        output MEM_InDelaySlot, Ext_Int, CP0_RdAddr,
        output WB_CP0Wr, WB_CP0Addr, WB_CP0Data,
        input  CP0_RdData, Exc_Flush, Exc_NPC,
        input  CP0_Status, CP0_Cause, CP0_EPC
    );

    modport slave (
        input  MEM_Valid, MEM_ExceptType, MEM_PC, MEM_ALUOut,
        input  MEM_InDelaySlot, Ext_Int, CP0_RdAddr,
        input  WB_CP0Wr, WB_CP0Addr, WB_CP0Data,
        output CP0_RdData, Exc_Flush, Exc_NPC,
        output CP0_Status, CP0_Cause, CP0_EPC
    );

endinterface

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: Count advances every second clock and
// raises TI when it steps onto Compare; MTC0 Compare clears TI.
module cp0_timer
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr,
    input  logic [4:0]  addr,
    input  logic [31:0] data,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    logic        toggle;
    logic [31:0] count_inc;

    assign count_inc = count + 32'd1;

    // Half-rate counter, compare match and MTC0 loads (loads win)
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
            toggle  <= 1'b0;
        end else begin
            toggle <= ~toggle;
            if (toggle) begin
                count <= count_inc;
                if (count_inc == compare)
                    ti <= 1'b1;
            end
            if (wr && addr == CP0_COUNT) begin
                count  <= data;
                toggle <= 1'b0;
            end
            if (wr && addr == CP0_COMPARE) begin
                compare <= data;
                ti      <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cp0_exception_unit.sv
// CP0 exception unit: prioritises MEM exceptions, updates CP0 state,
// issues flush/redirect. Optional timer enabled by CP0_TIMER_EN.
module cp0_exception_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
    input logic                 clk,
    input logic                 rst,
    cp0_exception_unit_if.slave bus
);

    status_t     status, status_n;
    cause_t      cause, cause_n, cause_rd;
    logic [31:0] epc, epc_n;
    logic [31:0] bva, bva_n;
    logic [31:0] count, compare;
    logic        ti;

    exc_flags_t  flags;
    logic        int_req;
    logic        exc;
    logic        eret;
    logic [4:0]  code;
    bva_sel_e    bsel;
    logic [31:0] rd;
    logic        wr;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] st_w, ca_w;

    assign wr    = bus.WB_CP0Wr;
    assign waddr = bus.WB_CP0Addr;
    assign wdata = bus.WB_CP0Data;

`ifdef CP0_TIMER_EN
    cp0_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .wr      (wr),
        .addr    (waddr),
        .data    (wdata),
        .count   (count),
        .compare (compare),
        .ti      (ti)
    );
`else
    assign count   = '0;
    assign compare = '0;
    assign ti      = 1'b0;
`endif

    assign flags = bus.MEM_Valid ? bus.MEM_ExceptType : '0;

    assign int_req = status.ie & ~status.exl
                   & (|(cause.ip & status.im))
                   & bus.MEM_Valid;

    // Pick the highest-priority exception and its ExcCode
    always_comb begin
        exc  = 1'b1;
        code = EXC_INT;
        bsel = BVA_KEEP;
        priority case (1'b1)
            flags[EF_INT] | int_req: code = EXC_INT;
            flags[EF_IFADDR]: begin
                code = EXC_ADEL;
                bsel = BVA_PC;
            end
            flags[EF_RI]:  code = EXC_RI;
            flags[EF_OV]:  code = EXC_OV;
            flags[EF_SYS]: code = EXC_SYS;
            flags[EF_BRK]: code = EXC_BP;
            flags[EF_RDADDR]: begin
                code = EXC_ADEL;
                bsel = BVA_ALU;
            end
            flags[EF_WRADDR]: begin
                code = EXC_ADES;
                bsel = BVA_ALU;
            end
            default: exc = 1'b0;
        endcase
    end

    assign eret = ~exc & flags[EF_ERET];

    assign bus.Exc_Flush = ~rst & (exc | eret);
    assign bus.Exc_NPC   = rst  ? '0
                         : exc  ? EXC_VECTOR
                         : eret ? epc
                         : '0;

    // Next CP0 state: MTC0 first, then exception/Eret overrides
    always_comb begin
        status_n = status;
        cause_n  = cause;
        epc_n    = epc;
        bva_n    = bva;
        cause_n.ip[7:2] = {bus.Ext_Int[5] | ti, bus.Ext_Int[4:0]};
        st_w = status_n;
        ca_w = cause_n;
        if (wr && waddr == CP0_STATUS) begin
            st_w = (st_w & ~STATUS_WMASK)
                 | (wdata & STATUS_WMASK);
            status_n = st_w;
        end
        if (wr && waddr == CP0_CAUSE) begin
            ca_w = (ca_w & ~CAUSE_WMASK)
                 | (wdata & CAUSE_WMASK);
            cause_n = ca_w;
        end
        if (wr && waddr == CP0_EPC)
            epc_n = wdata;
        if (exc) begin
            if (!status.exl) begin
                epc_n = bus.MEM_InDelaySlot
                      ? bus.MEM_PC - 32'd4
                      : bus.MEM_PC;
                cause_n.bd = bus.MEM_InDelaySlot;
            end
            status_n.exl     = 1'b1;
            cause_n.exc_code = code;
            unique case (bsel)
                BVA_PC:  bva_n = bus.MEM_PC;
                BVA_ALU: bva_n = bus.MEM_ALUOut;
                default: bva_n = bva;
            endcase
        end else if (eret) begin
            status_n.exl = 1'b0;
        end
    end

    // CP0 register file; reset cancels any pending update
    always_ff @(posedge clk) begin
        if (rst) begin
            status <= STATUS_RST;
            cause  <= '0;
            epc    <= '0;
            bva    <= '0;
        end else begin
            status <= status_n;
            cause  <= cause_n;
            epc    <= epc_n;
            bva    <= bva_n;
        end
    end

    always_comb begin
        cause_rd    = cause;
        cause_rd.ti = cause.ti | ti;
    end

    // MFC0 read mux on pre-edge state
    always_comb begin
        rd = '0;
        case (bus.CP0_RdAddr)
            CP0_BADVADDR: rd = bva;
            CP0_COUNT:    rd = count;
            CP0_COMPARE:  rd = compare;
            CP0_STATUS:   rd = status;
            CP0_CAUSE:    rd = cause_rd;
            CP0_EPC:      rd = epc;
            default:      rd = '0;
        endcase
        if (rst)
            rd = '0;
    end

    assign bus.CP0_RdData = rd;
    assign bus.CP0_Status = status;
    assign bus.CP0_Cause  = cause_rd;
    assign bus.CP0_EPC    = epc;

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Bench for cp0_exception_unit: directed vector table, hand sequences
// and randomized traffic against a behavioural CP0 model.
module tb_cp0_exception_unit;
    import cp0_pkg::*;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cp0_exception_unit_if bus();

    cp0_exception_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic        valid;
        logic [8:0]  et;
        logic [31:0] pc;
        logic [31:0] alu;
        logic        ds;
        logic [5:0]  ext;
        logic        wr;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  raddr;
        logic        flush;
        logic [31:0] npc;
        logic [31:0] rd;
    } vec_t;

    function automatic vec_t mk(
        logic v, logic [8:0] et, logic [31:0] pc, logic [31:0] alu,
        logic ds, logic [5:0] ext, logic wr, logic [4:0] wa,
        logic [31:0] wd, logic [4:0] ra, logic fl,
        logic [31:0] npc, logic [31:0] rd);
        vec_t r;
        r.valid = v;  r.et = et;  r.pc = pc;  r.alu = alu;
        r.ds = ds;  r.ext = ext;  r.wr = wr;  r.waddr = wa;
        r.wdata = wd;  r.raddr = ra;  r.flush = fl;
        r.npc = npc;  r.rd = rd;
        return r;
    endfunction

    task automatic drive(input logic v, input logic [8:0] et,
                         input logic [31:0] pc, input logic [31:0] alu,
                         input logic ds, input logic [5:0] ext,
                         input logic wr, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] ra);
        bus.MEM_Valid       = v;
        bus.MEM_ExceptType  = et;
        bus.MEM_PC          = pc;
        bus.MEM_ALUOut      = alu;
        bus.MEM_InDelaySlot = ds;
        bus.Ext_Int         = ext;
        bus.WB_CP0Wr        = wr;
        bus.WB_CP0Addr      = wa;
        bus.WB_CP0Data      = wd;
        bus.CP0_RdAddr      = ra;
    endtask

    task automatic idle(input logic [4:0] ra);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, ra);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_status, m_cause, m_epc, m_bva;
    logic [31:0] m_base, m_compare;
    int unsigned m_cyc;
    logic        m_ti;

    task automatic m_reset();
        m_status  = 32'h0040_0000;
        m_cause   = 0;
        m_epc     = 0;
        m_bva     = 0;
        m_base    = 0;
        m_compare = 0;
        m_cyc     = 0;
        m_ti      = 0;
    endtask

    function automatic logic [31:0] m_count();
`ifdef CP0_TIMER_EN
        return m_base + 32'(m_cyc / 2);
`else
        return 32'h0;
`endif
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:  return m_bva;
            5'd9:  return m_count();
`ifdef CP0_TIMER_EN
            5'd11: return m_compare;
`endif
            5'd12: return m_status;
            5'd13: return m_cause | (32'(m_ti) << 30);
            5'd14: return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [4:0] code_of(input int i);
        case (i)
            0: return 5'd0;
            1: return 5'd4;
            2: return 5'd10;
            3: return 5'd12;
            4: return 5'd8;
            5: return 5'd9;
            6: return 5'd4;
            default: return 5'd5;
        endcase
    endfunction

    // pick: -1 none, 0..7 exception in priority order, 8 eret
    task automatic m_eval(output logic fl, output logic [31:0] np,
                          output int pick);
        logic [8:0] f;
        logic ir;
        f  = bus.MEM_Valid ? bus.MEM_ExceptType : 9'h0;
        ir = m_status[0] & ~m_status[1]
           & (|(m_cause[15:8] & m_status[15:8])) & bus.MEM_Valid;
        f[0] = f[0] | ir;
        pick = -1;
        for (int i = 0; i < 8; i++)
            if (f[i] && pick < 0) pick = i;
        if (pick < 0 && f[8]) pick = 8;
        if (rst) begin
            fl = 0;
            np = 0;
        end else begin
            fl = (pick >= 0);
            np = (pick < 0) ? 32'h0 : (pick == 8) ? m_epc : VEC;
        end
    endtask

    task automatic m_edge();
        logic [31:0] st, ca, ep, bv, d, np;
        logic fl;
        int pick;
        if (rst) begin
            m_reset();
            return;
        end
        m_eval(fl, np, pick);
        st = m_status;  ca = m_cause;  ep = m_epc;  bv = m_bva;
        d  = bus.WB_CP0Data;
        ca[15:10] = {bus.Ext_Int[5] | m_ti, bus.Ext_Int[4:0]};
        if (bus.WB_CP0Wr) begin
            case (bus.WB_CP0Addr)
                5'd12: st = (st & ~32'hFF03) | (d & 32'hFF03);
                5'd13: ca = (ca & ~32'h0300) | (d & 32'h0300);
                5'd14: ep = d;
                default: ;
            endcase
        end
        if (pick >= 0 && pick < 8) begin
            if (!m_status[1]) begin
                ep = bus.MEM_InDelaySlot ? bus.MEM_PC - 4 : bus.MEM_PC;
                ca[31] = bus.MEM_InDelaySlot;
            end
            st[1] = 1'b1;
            ca[6:2] = code_of(pick);
            if (pick == 1) bv = bus.MEM_PC;
            else if (pick >= 6) bv = bus.MEM_ALUOut;
        end else if (pick == 8) begin
            st[1] = 1'b0;
        end
`ifdef CP0_TIMER_EN
        m_cyc++;
        if (m_cyc % 2 == 0 && m_count() == m_compare) m_ti = 1;
        if (bus.WB_CP0Wr && bus.WB_CP0Addr == 5'd9) begin
            m_base = d;
            m_cyc  = 0;
        end
        if (bus.WB_CP0Wr && bus.WB_CP0Addr == 5'd11) begin
            m_compare = d;
            m_ti      = 0;
        end
`endif
        m_status = st;  m_cause = ca;  m_epc = ep;  m_bva = bv;
    endtask

    function automatic logic [4:0] rnd_addr();
        case ($urandom % 7)
            0: return 5'd8;
            1: return 5'd9;
            2: return 5'd11;
            3: return 5'd12;
            4: return 5'd13;
            5: return 5'd14;
            default: return 5'($urandom);
        endcase
    endfunction

    vec_t tbl[$];

    initial begin
        logic        fl;
        logic [31:0] np;
        int          pk;
        logic [8:0]  et;

        // cycle-by-cycle directed vectors, starting right after reset
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,12,0,0,32'h0040_0000));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,13,0,0,0));
        tbl.push_back(mk(1,9'h018,32'hBFC0_0100,0,0,0,0,0,0,13,1,VEC,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,13,0,0,32'h30));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,14,0,0,32'hBFC0_0100));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,12,0,0,32'h0040_0002));
        tbl.push_back(mk(1,9'h100,0,0,0,0,0,0,0,12,1,32'hBFC0_0100,
                         32'h0040_0002));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,12,0,0,32'h0040_0000));
        tbl.push_back(mk(1,9'h080,32'h8000_0010,32'h3,1,0,0,0,0,8,
                         1,VEC,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,8,0,0,32'h3));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,14,0,0,32'h8000_000C));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,13,0,0,32'h8000_0014));
        tbl.push_back(mk(0,0,0,0,0,0,1,14,32'h8000_0200,14,0,0,
                         32'h8000_000C));
        tbl.push_back(mk(1,9'h100,0,0,0,0,0,0,0,14,1,32'h8000_0200,
                         32'h8000_0200));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,12,0,0,32'h0040_0000));
        tbl.push_back(mk(0,9'h008,0,0,0,0,0,0,0,12,0,0,32'h0040_0000));
        tbl.push_back(mk(0,0,0,0,0,0,1,12,32'h0000_0401,12,0,0,
                         32'h0040_0000));
        tbl.push_back(mk(0,0,0,0,0,1,0,0,0,12,0,0,32'h0040_0401));
        tbl.push_back(mk(0,0,0,0,0,1,0,0,0,13,0,0,32'h8000_0414));
        tbl.push_back(mk(1,0,32'h8000_1000,0,0,1,0,0,0,13,1,VEC,
                         32'h8000_0414));
        tbl.push_back(mk(0,0,0,0,0,1,0,0,0,13,0,0,32'h0000_0400));
        tbl.push_back(mk(0,0,0,0,0,1,0,0,0,12,0,0,32'h0040_0403));
        tbl.push_back(mk(0,0,0,0,0,1,0,0,0,14,0,0,32'h8000_1000));
        tbl.push_back(mk(1,0,0,0,0,1,0,0,0,13,0,0,32'h0000_0400));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,5,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,1,8,32'hFFFF_FFFF,8,0,0,32'h3));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,8,0,0,32'h3));
        tbl.push_back(mk(1,9'h006,32'h1234_5679,0,0,0,0,0,0,13,1,VEC,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,13,0,0,32'h10));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,8,0,0,32'h1234_5679));
        tbl.push_back(mk(1,9'h060,0,32'hDEAD,0,0,0,0,0,13,1,VEC,32'h10));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,13,0,0,32'h24));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,8,0,0,32'h1234_5679));

        rst = 1;
        idle(12);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;

        foreach (tbl[i]) begin
            drive(tbl[i].valid, tbl[i].et, tbl[i].pc, tbl[i].alu,
                  tbl[i].ds, tbl[i].ext, tbl[i].wr, tbl[i].waddr,
                  tbl[i].wdata, tbl[i].raddr);
            #2;
            chk($sformatf("tbl%0d.flush", i),
                32'(bus.Exc_Flush), 32'(tbl[i].flush));
            chk($sformatf("tbl%0d.npc", i), bus.Exc_NPC, tbl[i].npc);
            chk($sformatf("tbl%0d.rd", i), bus.CP0_RdData, tbl[i].rd);
            tick();
        end

        // reset asserted while an exception is presented
        rst = 1;
        drive(1, 9'h008, 32'h4444_0000, 0, 0, 0, 1, 14, 32'h1, 12);
        #2;
        chk("rst.flush", 32'(bus.Exc_Flush), 0);
        chk("rst.npc", bus.Exc_NPC, 0);
        chk("rst.rd", bus.CP0_RdData, 0);
        tick();
        rst = 0;
        idle(12);
        #2;
        chk("rst.status", bus.CP0_Status, 32'h0040_0000);
        chk("rst.cause", bus.CP0_Cause, 0);
        chk("rst.epc", bus.CP0_EPC, 0);

`ifdef CP0_TIMER_EN
        drive(0, 0, 0, 0, 0, 0, 1, 9, 32'h0, 9);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 11, 32'h3, 9);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 12, 32'h0000_8001, 9);
        tick();
        idle(9);
        repeat (4) tick();
        #2;
        chk("tmr.count", bus.CP0_RdData, 32'h3);
        chk("tmr.ti", 32'(bus.CP0_Cause[30]), 1);
        tick();
        drive(1, 0, 32'h8000_0040, 0, 0, 0, 0, 0, 0, 12);
        #2;
        chk("tmr.irq", 32'(bus.Exc_Flush), 1);
        chk("tmr.npc", bus.Exc_NPC, VEC);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 11, 32'h9, 12);
        #2;
        chk("tmr.exl", bus.CP0_Status, 32'h0040_8003);
        tick();
        idle(12);
        #2;
        chk("tmr.ticlr", 32'(bus.CP0_Cause[30]), 0);
`else
        drive(0, 0, 0, 0, 0, 0, 1, 9, 32'h55, 9);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 11, 32'h66, 9);
        #2;
        chk("notmr.count", bus.CP0_RdData, 0);
        tick();
        idle(11);
        #2;
        chk("notmr.compare", bus.CP0_RdData, 0);
        chk("notmr.ti", 32'(bus.CP0_Cause[30]), 0);
        tick();
`endif

        // randomized traffic against the model
        rst = 1;
        idle(0);
        tick();
        m_reset();
        rst = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 9; b++)
                et[b] = ($urandom % 12 == 0);
            drive(($urandom % 4) != 0, et, $urandom, $urandom,
                  1'($urandom), ($urandom % 4 == 0) ? 6'($urandom) : 6'h0,
                  ($urandom % 4 == 0), rnd_addr(), $urandom, rnd_addr());
            rst = ($urandom % 200 == 0);
            #2;
            m_eval(fl, np, pk);
            chk("rnd.flush", 32'(bus.Exc_Flush), 32'(fl));
            chk("rnd.npc", bus.Exc_NPC, np);
            chk("rnd.rd", bus.CP0_RdData,
                rst ? 32'h0 : m_read(bus.CP0_RdAddr));
            chk("rnd.status", bus.CP0_Status, m_status);
            chk("rnd.cause", bus.CP0_Cause, m_read(5'd13));
            chk("rnd.epc", bus.CP0_EPC, m_epc);
            @(posedge clk);
            m_edge();
            @(negedge clk);
        end
        rst = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
